spi_target: RTL

- SPI mode-0 target (responder): the device-side counterpart of the SoC's SPI initiator ports (spi_cen/spi_sclk/mosi/miso).
- Oversamples the external SPI pins in the system clock domain.
- Delivers received bytes to local logic and shifts out bytes supplied through a one-entry transmit buffer.
- Used as an on-board peripheral bridge and as a synthesizable loopback target for SPI bring-up.

---
 rtl/spi_target_pkg.sv | 10 +
 rtl/spi_target_sync.sv | 19 +
 rtl/spi_target.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI mode-0 target.
package spi_target_pkg;
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int         BIT_CNT_W         = 3;
  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;
endpackage

// File: rtl/spi_target_sync.sv
// Multi-flop synchronizer for one asynchronous input pin, with a selectable reset level.
module spi_target_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{RST_VAL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled pins, byte receive, one-entry transmit buffer.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_BYTE   = FILL_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_cen,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_active
);
  logic cen_s, sclk_s, mosi_s;

  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cen (
    .clk(clk), .rst_n(rst_n), .d_i(spi_cen), .q_o(cen_s));
  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(spi_sclk), .q_o(sclk_s));
  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(spi_mosi), .q_o(mosi_s));

  state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 cen_prev_q, sclk_prev_q;
  logic [6:0]           rx_shift_q, rx_shift_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [7:0]           tx_buf_q, tx_buf_d;
  logic                 tx_full_q, tx_full_d;
  logic [7:0]           tx_shift_q, tx_shift_d;
  logic                 miso_q, miso_d;
  logic                 miso_oe_q, miso_oe_d;
  logic                 underrun_q, underrun_d;
  logic                 fstart_q, fstart_d;
  logic                 fend_q, fend_d;
  logic                 active_q, active_d;

  logic cen_fall, cen_rise, sclk_rise, sclk_fall, reload;
  logic [7:0] load_byte;

  assign cen_fall  =  cen_prev_q  & ~cen_s;
  assign cen_rise  = ~cen_prev_q  &  cen_s;
  assign sclk_rise = ~sclk_prev_q &  sclk_s;
  assign sclk_fall =  sclk_prev_q & ~sclk_s;
  assign load_byte = tx_full_q ? tx_buf_q : FILL_BYTE;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    tx_shift_d = tx_shift_q;
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;
    underrun_d = 1'b0;
    fstart_d   = 1'b0;
    fend_d     = 1'b0;
    active_d   = active_q;
    reload     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cen_fall) begin
          state_d   = ST_SHIFT;
          fstart_d  = 1'b1;
          active_d  = 1'b1;
          miso_oe_d = 1'b1;
          bit_cnt_d = '0;
          reload    = 1'b1;
        end
      end
      default: begin
        // cen rise wins over any sclk edge seen in the same cycle
        if (cen_rise) begin
          state_d   = ST_IDLE;
          fend_d    = 1'b1;
          active_d  = 1'b0;
          miso_oe_d = 1'b0;
          miso_d    = 1'b1;
          bit_cnt_d = '0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[5:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == '1) begin
            rx_data_d  = {rx_shift_q, mosi_s};
            rx_valid_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            miso_d     = tx_shift_q[6];
          end else begin
            reload = 1'b1;
          end
        end
      end
    endcase

    if (reload) begin
      tx_shift_d = load_byte;
      miso_d     = load_byte[7];
      if (tx_full_q) tx_full_d  = 1'b0;
      else           underrun_d = 1'b1;
    end

    // A write landing on a reload cycle only refills the buffer for the next byte
    if (tx_valid && !tx_full_q) begin
      tx_full_d = 1'b1;
      tx_buf_d  = tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      cen_prev_q  <= 1'b1;
      sclk_prev_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_full_q   <= 1'b0;
      miso_q      <= 1'b1;
      miso_oe_q   <= 1'b0;
      underrun_q  <= 1'b0;
      fstart_q    <= 1'b0;
      fend_q      <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cen_prev_q  <= cen_s;
      sclk_prev_q <= sclk_s;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_full_q   <= tx_full_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      underrun_q  <= underrun_d;
      fstart_q    <= fstart_d;
      fend_q      <= fend_d;
      active_q    <= active_d;
    end
  end

  // Pure datapath registers; their contents are qualified by the control state above
  always_ff @(posedge clk) begin
    rx_shift_q <= rx_shift_d;
    tx_buf_q   <= tx_buf_d;
    tx_shift_q <= tx_shift_d;
  end

  assign spi_miso     = miso_q;
  assign spi_miso_oe  = miso_oe_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign tx_ready     = ~tx_full_q;
  assign tx_underrun  = underrun_q;
  assign frame_start  = fstart_q;
  assign frame_end    = fend_q;
  assign frame_active = active_q;
endmodule
